mips32_core: RTL and testbench
==============================

# mips32_core

Single-cycle 32-bit MIPS processor: fetches, decodes, executes and retires one instruction per rising clock edge from an internal instruction memory, with an internal register file and data memory. It is the top of the processor hierarchy, has no external data ports, and is observed and initialised through its internal arrays. Benches preload registers, instructions and data by backdoor, run N cycles, then dump the register file and data memory.

## Interface
- Parameters: none; sizes below are fixed.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- Fixed internal hierarchy for backdoor access:
  - Instance `regs` holds array `registers` [0:31] of 32 bits.
  - Instance `im` holds array `instr_memory` [0:255] of 32 bits.
  - Instance `mes` holds array `memory` [0:255] of 32 bits.

## Operation
- PC: 32 bits; instruction = im.instr_memory[PC[9:2]]; PC[1:0] ignored; index wraps modulo 256.
- Register file:
  - Two combinational read ports.
  - One write port, written on the rising edge.
  - Writes to $0 are discarded; reads of $0 return 0.
- Data memory:
  - Combinational read; write on the rising edge.
  - Word index = ALU result[9:2]; word accesses only.
- Supported instructions; arithmetic wraps modulo 2^32 and never traps:
  - R-type (op 0), by funct: add 0x20, addu 0x21, sub 0x22, subu 0x23, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A (signed), sltu 0x2B, sll 0x00, srl 0x02, sra 0x03 (shift rt by shamt), jr 0x08. Destination is rd.
  - I-type, destination rt:
    - addi 0x08, addiu 0x09, slti 0x0A, sltiu 0x0B: sign-extended imm.
    - andi 0x0C, ori 0x0D, xori 0x0E: zero-extended imm.
    - lui 0x0F: rt = imm<<16.
    - lw 0x23, sw 0x2B: address = rs + sext(imm).
    - beq 0x04, bne 0x05.
  - J-type: j 0x02; jal 0x03 writes PC+4 to $31.
- Next PC:
  - Taken branch: PC+4 + (sext(imm)<<2).
  - j/jal: {PC+4[31:28], target, 2'b00}.
  - jr: rs.
  - Otherwise: PC+4.
- No branch delay slot.
- Any unlisted opcode/funct executes as NOP: no register or memory write, PC+4.

## Timing
- Single cycle: every instruction, including lw and sw, completes in exactly one clock period.
- On each rising edge, all of these update simultaneously from the current instruction: PC, one register-file write, one data-memory write.
- rst_n low asynchronously forces PC = 0, regardless of clk.
- Reset does not clear the register file or either memory, so backdoor preloads survive reset.
- A rising edge while rst_n is low makes no state change.
- After reset deasserts, the first rising edge retires instr_memory[0].
- A register written by instruction k is read with its new value by instruction k+1; no hazards exist.
- sw followed by lw to the same address returns the stored word on the next cycle.
- The branch condition uses register values read before the current edge's write.
- No output ports and no reset values to define; all results are observed through `regs.registers` and `mes.memory`.

## Test plan
- ALU:
  - Stimulus: $1=5, $2=3; add $3,$1,$2; sub $4,$1,$2; slt $5,$2,$1; and $6,$1,$2; or $7,$1,$2.
  - Required: $3=8, $4=2, $5=1, $6=1, $7=7 after 5 cycles.
- Immediates:
  - Stimulus: addi $1,$0,-1; ori $2,$0,0xFFFF; lui $3,0x1234; sll $4,$2,4.
  - Required: $1=0xFFFFFFFF, $2=0x0000FFFF, $3=0x12340000, $4=0x000FFFF0.
- Memory:
  - Stimulus: memory[2]=0xDEADBEEF; lw $1,8($0); sw $1,12($0); lw $2,12($0).
  - Required: $1=$2=0xDEADBEEF, memory[3]=0xDEADBEEF.
- Control flow:
  - beq $0,$0,+1 skips the next addi.
  - bne with equal operands falls through.
  - jal to word 10 sets $31=PC+4 and continues at 0x28.
  - jr $31 returns.
- $0 / NOP:
  - addi $0,$0,7 leaves $0=0.
  - Undefined opcode 0x3F changes no state and advances PC by 4.
- Reset:
  - Stimulus: pull rst_n low mid-program, between clock edges.
  - Required: PC=0 immediately; registers and memories keep their values; execution restarts at instr_memory[0].

Source files
------------

// File: rtl/mips32_core.sv
// Single-cycle MIPS32 core: one instruction fetched, executed and retired per clock.
// Register file, instruction memory and data memory are internal and preloaded by backdoor.

module mips32_regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] registers [0:31];

    always_ff @(posedge clk) begin
        if (we && wa != 5'd0) begin
            registers[wa] <= wd;
        end
    end

    // $0 reads as zero whatever the array entry holds
    assign rd1 = (ra1 == 5'd0) ? 32'd0 : registers[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : registers[ra2];
endmodule

module mips32_imem (
    input  logic        clk,
    input  logic        we,
    input  logic [7:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [7:0]  addr,
    output logic [31:0] rdata
);
    logic [31:0] instr_memory [0:255];

    // Write port exists for loaders; the core ties it off and programs arrive by backdoor
    always_ff @(posedge clk) begin
        if (we) begin
            instr_memory[waddr] <= wdata;
        end
    end

    assign rdata = instr_memory[addr];
endmodule

module mips32_dmem (
    input  logic        clk,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [31:0] wd,
    output logic [31:0] rd
);
    logic [31:0] memory [0:255];

    always_ff @(posedge clk) begin
        if (we) begin
            memory[addr] <= wd;
        end
    end

    assign rd = memory[addr];
endmodule

module mips32_core (
    input logic clk,
    input logic rst_n
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00, F_SRL  = 6'h02, F_SRA = 6'h03, F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
    localparam logic [5:0] F_AND = 6'h24, F_OR   = 6'h25, F_XOR = 6'h26, F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A, F_SLTU = 6'h2B;

    logic [31:0] pc, next_pc, pc_plus4, instr;
    logic [31:0] rs_val, rt_val, sext_imm, zext_imm, mem_addr, mem_rdata;
    logic [31:0] br_target, jmp_target, wb_data;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt, wb_reg;
    logic        reg_we, mem_we;
    logic        unused_addr_bits;

    assign op       = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign sext_imm = {{16{instr[15]}}, instr[15:0]};
    assign zext_imm = {16'd0, instr[15:0]};

    assign pc_plus4   = pc + 32'd4;
    assign br_target  = pc_plus4 + {sext_imm[29:0], 2'b00};
    assign jmp_target = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign mem_addr   = rs_val + sext_imm;

    assign unused_addr_bits = ^{mem_addr[31:10], mem_addr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= 32'd0;
        end else begin
            pc <= next_pc;
        end
    end

    mips32_imem im (
        .clk   (clk),
        .we    (1'b0),
        .waddr (8'd0),
        .wdata (32'd0),
        .addr  (pc[9:2]),
        .rdata (instr)
    );

    // Writes are gated by rst_n so an edge during reset leaves all state untouched
    mips32_regfile regs (
        .clk (clk),
        .we  (reg_we && rst_n),
        .ra1 (rs),
        .ra2 (rt),
        .wa  (wb_reg),
        .wd  (wb_data),
        .rd1 (rs_val),
        .rd2 (rt_val)
    );

    mips32_dmem mes (
        .clk (clk),
        .we  (mem_we && rst_n),
        .addr(mem_addr[9:2]),
        .wd  (rt_val),
        .rd  (mem_rdata)
    );

    always_comb begin
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        wb_reg  = rt;
        wb_data = 32'd0;
        next_pc = pc_plus4;
        case (op)
            OP_RTYPE: begin
                wb_reg = rd;
                reg_we = 1'b1;
                case (funct)
                    F_ADD, F_ADDU: wb_data = rs_val + rt_val;
                    F_SUB, F_SUBU: wb_data = rs_val - rt_val;
                    F_AND:         wb_data = rs_val & rt_val;
                    F_OR:          wb_data = rs_val | rt_val;
                    F_XOR:         wb_data = rs_val ^ rt_val;
                    F_NOR:         wb_data = ~(rs_val | rt_val);
                    F_SLT:         wb_data = {31'd0, $signed(rs_val) < $signed(rt_val)};
                    F_SLTU:        wb_data = {31'd0, rs_val < rt_val};
                    F_SLL:         wb_data = rt_val << shamt;
                    F_SRL:         wb_data = rt_val >> shamt;
                    F_SRA:         wb_data = $signed(rt_val) >>> shamt;
                    F_JR: begin
                        reg_we  = 1'b0;
                        next_pc = rs_val;
                    end
                    default:       reg_we = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                reg_we  = 1'b1;
                wb_data = rs_val + sext_imm;
            end
            OP_SLTI: begin
                reg_we  = 1'b1;
                wb_data = {31'd0, $signed(rs_val) < $signed(sext_imm)};
            end
            OP_SLTIU: begin
                reg_we  = 1'b1;
                wb_data = {31'd0, rs_val < sext_imm};
            end
            OP_ANDI: begin
                reg_we  = 1'b1;
                wb_data = rs_val & zext_imm;
            end
            OP_ORI: begin
                reg_we  = 1'b1;
                wb_data = rs_val | zext_imm;
            end
            OP_XORI: begin
                reg_we  = 1'b1;
                wb_data = rs_val ^ zext_imm;
            end
            OP_LUI: begin
                reg_we  = 1'b1;
                wb_data = {instr[15:0], 16'd0};
            end
            OP_LW: begin
                reg_we  = 1'b1;
                wb_data = mem_rdata;
            end
            OP_SW:  mem_we = 1'b1;
            OP_BEQ: if (rs_val == rt_val) next_pc = br_target;
            OP_BNE: if (rs_val != rt_val) next_pc = br_target;
            OP_J:   next_pc = jmp_target;
            OP_JAL: begin
                reg_we  = 1'b1;
                wb_reg  = 5'd31;
                wb_data = pc_plus4;
                next_pc = jmp_target;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mips32_core.sv
// Bench for mips32_core: an ISA-level interpreter runs alongside the core and is compared
// every cycle, plus hand-computed register/memory values for each directed program.

module tb_mips32_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mips32_core dut (
        .clk   (clk),
        .rst_n (rst_n)
    );

    always #5 clk = ~clk;

    logic [31:0] m_regs [0:31];
    logic [31:0] m_imem [0:255];
    logic [31:0] m_mem  [0:255];
    logic [31:0] m_pc = 32'd0;
    logic        check_en = 1'b0;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_op(input int funct, input int rs, input int rt,
                                         input int rd, input int sh);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], funct[5:0]};
    endfunction

    function automatic logic [31:0] i_op(input int op, input int rs, input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] j_op(input int op, input int target);
        return {op[5:0], target[25:0]};
    endfunction

    // Backdoor loads go to the core and the model together
    task automatic clear_all();
        for (int i = 0; i < 256; i++) begin
            dut.im.instr_memory[i] = 32'd0;
            m_imem[i] = 32'd0;
            dut.mes.memory[i] = 32'd0;
            m_mem[i] = 32'd0;
        end
        for (int i = 0; i < 32; i++) begin
            dut.regs.registers[i] = 32'd0;
            m_regs[i] = 32'd0;
        end
    endtask

    task automatic set_instr(input int i, input logic [31:0] w);
        dut.im.instr_memory[i] = w;
        m_imem[i] = w;
    endtask

    task automatic set_reg(input int r, input logic [31:0] v);
        dut.regs.registers[r] = v;
        m_regs[r] = v;
    endtask

    task automatic set_mem(input int i, input logic [31:0] v);
        dut.mes.memory[i] = v;
        m_mem[i] = v;
    endtask

    // Instruction-set interpreter: reads operands first, then commits one result
    task automatic model_step();
        logic [31:0] ins, a, b, se, ze, pc4, npc, wv, addr;
        logic [5:0]  op, fn;
        logic [4:0]  sh;
        int          wr;
        bit          mw;
        ins  = m_imem[m_pc[9:2]];
        op   = ins[31:26];
        fn   = ins[5:0];
        sh   = ins[10:6];
        a    = m_regs[ins[25:21]];
        b    = m_regs[ins[20:16]];
        se   = {{16{ins[15]}}, ins[15:0]};
        ze   = {16'd0, ins[15:0]};
        addr = a + se;
        pc4  = m_pc + 32'd4;
        npc  = pc4;
        wr   = -1;
        wv   = 32'd0;
        mw   = 1'b0;
        case (op)
            6'h00: begin
                wr = int'(ins[15:11]);
                case (fn)
                    6'h20, 6'h21: wv = a + b;
                    6'h22, 6'h23: wv = a - b;
                    6'h24: wv = a & b;
                    6'h25: wv = a | b;
                    6'h26: wv = a ^ b;
                    6'h27: wv = ~(a | b);
                    6'h2A: wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2B: wv = (a < b) ? 32'd1 : 32'd0;
                    6'h00: wv = b << sh;
                    6'h02: wv = b >> sh;
                    6'h03: wv = $signed(b) >>> sh;
                    6'h08: begin wr = -1; npc = a; end
                    default: wr = -1;
                endcase
            end
            6'h08, 6'h09: begin wr = int'(ins[20:16]); wv = a + se; end
            6'h0A: begin wr = int'(ins[20:16]); wv = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
            6'h0B: begin wr = int'(ins[20:16]); wv = (a < se) ? 32'd1 : 32'd0; end
            6'h0C: begin wr = int'(ins[20:16]); wv = a & ze; end
            6'h0D: begin wr = int'(ins[20:16]); wv = a | ze; end
            6'h0E: begin wr = int'(ins[20:16]); wv = a ^ ze; end
            6'h0F: begin wr = int'(ins[20:16]); wv = {ins[15:0], 16'd0}; end
            6'h23: begin wr = int'(ins[20:16]); wv = m_mem[addr[9:2]]; end
            6'h2B: mw = 1'b1;
            6'h04: if (a == b) npc = pc4 + (se << 2);
            6'h05: if (a != b) npc = pc4 + (se << 2);
            6'h02: npc = {pc4[31:28], ins[25:0], 2'b00};
            6'h03: begin wr = 31; wv = pc4; npc = {pc4[31:28], ins[25:0], 2'b00}; end
            default: ;
        endcase
        if (mw) m_mem[addr[9:2]] = b;
        if (wr > 0) m_regs[wr] = wv;
        m_pc = npc;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_pc = 32'd0;
        else model_step();
    end

    // Whole architectural state against the model, once per cycle
    always @(negedge clk) begin : cmp_blk
        int fr;
        int fm;
        if (check_en) begin
            check("pc", dut.pc, m_pc);
            fr = -1;
            fm = -1;
            for (int i = 0; i < 32; i++)
                if (fr < 0 && dut.regs.registers[i] !== m_regs[i]) fr = i;
            for (int i = 0; i < 256; i++)
                if (fm < 0 && dut.mes.memory[i] !== m_mem[i]) fm = i;
            total += 2;
            if (fr >= 0) begin
                bad++;
                $display("FAIL regs[%0d]: got 0x%08h expected 0x%08h", fr,
                         dut.regs.registers[fr], m_regs[fr]);
            end
            if (fm >= 0) begin
                bad++;
                $display("FAIL mem[%0d]: got 0x%08h expected 0x%08h", fm,
                         dut.mes.memory[fm], m_mem[fm]);
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic enter_reset();
        rst_n = 1'b0;
        #1;
    endtask

    task automatic leave_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        clear_all();
        #2;
        check("reset_pc", dut.pc, 32'd0);
        check_en = 1'b1;

        // ALU
        set_reg(1, 32'd5);
        set_reg(2, 32'd3);
        set_instr(0,  r_op('h20, 1, 2, 3, 0));
        set_instr(1,  r_op('h22, 1, 2, 4, 0));
        set_instr(2,  r_op('h2A, 2, 1, 5, 0));
        set_instr(3,  r_op('h24, 1, 2, 6, 0));
        set_instr(4,  r_op('h25, 1, 2, 7, 0));
        set_instr(5,  r_op('h26, 1, 2, 8, 0));
        set_instr(6,  r_op('h27, 1, 2, 9, 0));
        set_instr(7,  r_op('h03, 0, 9, 10, 1));
        set_instr(8,  r_op('h02, 0, 9, 11, 1));
        set_instr(9,  r_op('h2B, 1, 9, 12, 0));
        set_instr(10, r_op('h2A, 1, 9, 13, 0));
        leave_reset();
        run(5);
        check("add", dut.regs.registers[3], 32'd8);
        check("sub", dut.regs.registers[4], 32'd2);
        check("slt", dut.regs.registers[5], 32'd1);
        check("and", dut.regs.registers[6], 32'd1);
        check("or",  dut.regs.registers[7], 32'd7);
        run(6);
        check("xor",  dut.regs.registers[8],  32'd6);
        check("nor",  dut.regs.registers[9],  32'hFFFF_FFF8);
        check("sra",  dut.regs.registers[10], 32'hFFFF_FFFC);
        check("srl",  dut.regs.registers[11], 32'h7FFF_FFFC);
        check("sltu", dut.regs.registers[12], 32'd1);
        check("slt_neg", dut.regs.registers[13], 32'd0);

        // Immediates
        enter_reset();
        clear_all();
        set_instr(0, i_op('h08, 0, 1, -1));
        set_instr(1, i_op('h0D, 0, 2, 'hFFFF));
        set_instr(2, i_op('h0F, 0, 3, 'h1234));
        set_instr(3, r_op('h00, 0, 2, 4, 4));
        set_instr(4, i_op('h0A, 1, 5, 0));
        set_instr(5, i_op('h0B, 1, 6, 'hFFFF));
        set_instr(6, i_op('h0C, 1, 7, 'h00F0));
        set_instr(7, i_op('h0E, 2, 8, 'h00FF));
        set_instr(8, i_op('h09, 3, 9, 'h8000));
        leave_reset();
        run(9);
        check("addi", dut.regs.registers[1], 32'hFFFF_FFFF);
        check("ori",  dut.regs.registers[2], 32'h0000_FFFF);
        check("lui",  dut.regs.registers[3], 32'h1234_0000);
        check("sll",  dut.regs.registers[4], 32'h000F_FFF0);
        check("slti", dut.regs.registers[5], 32'd1);
        check("sltiu", dut.regs.registers[6], 32'd0);
        check("andi", dut.regs.registers[7], 32'h0000_00F0);
        check("xori", dut.regs.registers[8], 32'h0000_FF00);
        check("addiu", dut.regs.registers[9], 32'h1233_8000);

        // Memory
        enter_reset();
        clear_all();
        set_mem(2, 32'hDEAD_BEEF);
        set_instr(0, i_op('h23, 0, 1, 8));
        set_instr(1, i_op('h2B, 0, 1, 12));
        set_instr(2, i_op('h23, 0, 2, 12));
        leave_reset();
        run(3);
        check("lw1", dut.regs.registers[1], 32'hDEAD_BEEF);
        check("lw2", dut.regs.registers[2], 32'hDEAD_BEEF);
        check("sw",  dut.mes.memory[3],     32'hDEAD_BEEF);

        // Control flow
        enter_reset();
        clear_all();
        set_instr(0,  i_op('h04, 0, 0, 1));
        set_instr(1,  i_op('h08, 0, 1, 1));
        set_instr(2,  i_op('h05, 0, 0, 5));
        set_instr(3,  i_op('h08, 0, 2, 2));
        set_instr(4,  j_op('h03, 10));
        set_instr(5,  i_op('h08, 0, 4, 4));
        set_instr(6,  j_op('h02, 6));
        set_instr(10, i_op('h08, 0, 3, 3));
        set_instr(11, r_op('h08, 31, 0, 0, 0));
        leave_reset();
        run(4);
        check("jal_pc", dut.pc, 32'h0000_0028);
        run(6);
        check("beq_skip",  dut.regs.registers[1],  32'd0);
        check("bne_fall",  dut.regs.registers[2],  32'd2);
        check("jal_body",  dut.regs.registers[3],  32'd3);
        check("jr_return", dut.regs.registers[4],  32'd4);
        check("jal_link",  dut.regs.registers[31], 32'd20);
        check("j_loop_pc", dut.pc, 32'd24);

        // $0 and undefined encodings
        enter_reset();
        clear_all();
        set_reg(1, 32'd1);
        set_reg(2, 32'd2);
        set_reg(5, 32'h55);
        set_instr(0, i_op('h08, 0, 0, 7));
        set_instr(1, 32'hFC22_0004);
        set_instr(2, r_op('h3F, 1, 2, 5, 0));
        set_instr(3, i_op('h08, 0, 6, 6));
        leave_reset();
        run(1);
        check("zero_reg", dut.regs.registers[0], 32'd0);
        run(1);
        check("undef_pc", dut.pc, 32'd8);
        run(2);
        check("undef_funct", dut.regs.registers[5], 32'h55);
        check("after_nop", dut.regs.registers[6], 32'd6);

        // Reset mid-program
        enter_reset();
        clear_all();
        set_instr(0, i_op('h08, 1, 1, 1));
        set_instr(1, i_op('h2B, 0, 1, 16));
        set_instr(2, j_op('h02, 0));
        leave_reset();
        run(7);
        check("pre_reset_pc", dut.pc, 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_pc", dut.pc, 32'd0);
        check("reset_keeps_reg", dut.regs.registers[1], 32'd3);
        check("reset_keeps_mem", dut.mes.memory[4], 32'd2);
        run(2);
        check("held_reset_reg", dut.regs.registers[1], 32'd3);
        check("held_reset_pc", dut.pc, 32'd0);
        leave_reset();
        run(1);
        check("restart_reg", dut.regs.registers[1], 32'd4);
        check("restart_pc", dut.pc, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
